arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
- Requester-side agent for the 4-way round-robin arbiter; one instance per arbiter client.
- Buffers upstream commands in a small FIFO and holds `req` while any command is pending.
- Consumes the arbiter's one-cycle `grant` pulse to pop exactly one command and drive it onto the shared bus segment for one cycle.
- Tolerates the arbiter's behaviour of never granting the same client on consecutive cycles.

Parameters:
- DATA_W, 32, width of command payload and bus data.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TIMEOUT, 64, starvation watchdog limit in cycles. Used only with REQ_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  upstream command valid.
- cmd_data  input  DATA_W  upstream command payload.
- cmd_ready  output  1  FIFO can accept a command.
- req  output  1  request to arbiter.
- grant  input  1  this client's grant bit from the arbiter (registered, single-cycle pulse).
- bus_valid  output  1  granted command on the shared bus this cycle.
- bus_data  output  DATA_W  granted command payload.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err_spurious  output  1  sticky: grant received while FIFO empty.
- err_timeout  output  1  sticky starvation flag. Tied 0 without REQ_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n low):
  - FIFO empty; wr/rd pointers 0; level=0.
  - req=0, bus_valid=0, bus_data=0, err_spurious=0, err_timeout=0.
  - cmd_ready=1 once reset is released.
- FIFO:
  - Pointers are $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - Empty when pointers are equal. Full when the MSBs differ and the index bits are equal.
  - Index wraps from DEPTH-1 to 0.
- Push: cmd_valid & cmd_ready at a clock edge writes cmd_data at wr_ptr.
  - cmd_ready = !full, combinational from registered state.
  - A push is refused when full, even if a pop occurs in the same cycle.
- req = !empty, combinational from registered pointers.
  - req rises the cycle after the first push into an empty FIFO.
  - req falls the cycle after the pop of the last entry.
- Pop:
  - A clock edge with grant=1 and !empty pops the head entry.
  - At that same edge: bus_valid<=1 and bus_data<=head.
  - Latency grant->bus_valid is 1 cycle.
  - When no pop occurs, bus_valid<=0 and bus_data holds its previous value.
- Grant behaviour:
  - grant is at most one cycle wide.
  - A grant that is held high for multiple cycles is treated as one pop per cycle. This is legal for this block, but the arbiter never produces it.
- Simultaneous push and pop: both happen in the same cycle.
  - level is unchanged; req stays 1.
  - If the FIFO held 1 entry, the popped entry is the old head and the new entry becomes the head.
- Spurious grant: grant=1 while empty.
  - No pop, no pointer change, bus_valid<=0.
  - err_spurious<=1. It stays set until reset.
- level = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Reset during operation:
  - All pending commands are dropped.
  - req and bus_valid deassert immediately, asynchronously.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- Enabled:
  - A wait counter (width $clog2(TIMEOUT+1)) increments each cycle that req=1 and grant=0.
  - It clears on any grant and whenever req=0.
  - When the counter reaches TIMEOUT, err_timeout<=1. The flag is sticky until reset, and the counter saturates at TIMEOUT.
- Disabled: no counter logic; err_timeout is constant 0.

Test Plan:
- Reset then idle, with grant=0 and cmd_valid=0 → req=0, bus_valid=0, level=0, cmd_ready=1, err flags 0.
- Push 0xA5 and hold req; pulse grant 3 cycles later → bus_valid=1, bus_data=0xA5 on the cycle after grant; req=0 the following cycle; level returns to 0.
- Push 4 entries 0x1..0x4 (DEPTH=4) → cmd_ready=0 at level=4 and a 5th push is refused. Then grant pulses every other cycle → bus_data sequence 0x1,0x2,0x3,0x4; then wrap test: push 0x5..0x8 and drain, in-order.
- Level 1 (0x10); push 0x20 in the same cycle as grant → bus_data=0x10, level stays 1, req stays 1; next grant → 0x20.
- Grant pulse while empty → no bus_valid, err_spurious=1 and held; a subsequent normal push/grant works.
- With REQ_TIMEOUT_EN and TIMEOUT=8: push, withhold grant 8 cycles → err_timeout=1. Rerun with grant at cycle 7 → err_timeout stays 0. Also assert rst_n mid-drain → req=0, level=0 immediately.

Source files
------------

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - requester agent: command FIFO, req/grant handshake, one-cycle bus drive
// Optional starvation watchdog enabled by defining REQ_TIMEOUT_EN.
module arb_requester #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     cmd_ready,
  output logic                     req,
  input  logic                     grant,
  output logic                     bus_valid,
  output logic [DATA_W-1:0]        bus_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_spurious,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              err_spurious_q, err_spurious_d;
  logic              empty, full, push, pop;

  // Pointer MSB is the wrap bit: equal index with differing wrap bits means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign pop   = grant && !empty;

  assign cmd_ready    = !full;
  assign req          = !empty;
  assign level        = wr_ptr_q - rd_ptr_q;
  assign bus_valid    = bus_valid_q;
  assign bus_data     = bus_data_q;
  assign err_spurious = err_spurious_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    mem_d          = mem_q;
    bus_valid_d    = pop;
    bus_data_d     = bus_data_q;
    err_spurious_d = err_spurious_q || (grant && empty);
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = cmd_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      bus_data_d = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      mem_q          <= '{default: '0};
      bus_valid_q    <= 1'b0;
      bus_data_q     <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_q          <= mem_d;
      bus_valid_q    <= bus_valid_d;
      bus_data_q     <= bus_data_d;
      err_spurious_q <= err_spurious_d;
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_timeout_q, err_timeout_d;

  // Counts cycles spent requesting without a grant; saturates at TMAX.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
    if (empty || grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != TMAX) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
    if (wait_cnt_d == TMAX) begin
      err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  // TIMEOUT is meaningful only with the watchdog; this is constant 0.
  assign err_timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - scoreboard bench for arb_requester (DEPTH=4, TIMEOUT=8)
// Directed stimulus queues expected bus words; a negedge monitor pops and compares.
module tb_arb_requester;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_ready;
  logic              req;
  logic              grant = 1'b0;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [2:0]        level;
  logic              err_spurious;
  logic              err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

`ifdef REQ_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  arb_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .req(req), .grant(grant), .bus_valid(bus_valid),
    .bus_data(bus_data), .level(level), .err_spurious(err_spurious),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [DATA_W-1:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic grant_pulse(input logic [DATA_W-1:0] e);
    exp_q.push_back(e);
    grant = 1'b1;
    step();
    grant = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bus_unexpected: bus_valid=1 data=%h, required no output", bus_data);
        end else begin
          e = exp_q.pop_front();
          check("bus_data", bus_data, e);
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(req), 0);
    check("rst_bus_valid", 32'(bus_valid), 0);
    check("rst_bus_data", bus_data, 0);
    check("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    step();
    check("idle_cmd_ready", 32'(cmd_ready), 1);
    check("idle_err_spurious", 32'(err_spurious), 0);
    check("idle_err_timeout", 32'(err_timeout), 0);

    // single command, grant after 3 cycles
    push_cmd(32'hA5);
    check("single_req", 32'(req), 1);
    check("single_level", 32'(level), 1);
    repeat (3) step();
    grant_pulse(32'hA5);
    check("single_bus_valid", 32'(bus_valid), 1);
    check("single_req_drop", 32'(req), 0);
    check("single_level_0", 32'(level), 0);
    step();
    check("single_bus_valid_drop", 32'(bus_valid), 0);

    // fill, refuse 5th push, drain every other cycle
    for (int i = 1; i <= 4; i++) push_cmd(32'(i));
    check("full_level", 32'(level), 4);
    check("full_cmd_ready", 32'(cmd_ready), 0);
    push_cmd(32'h99);
    check("full_refused_level", 32'(level), 4);
    for (int i = 1; i <= 4; i++) begin
      grant_pulse(32'(i));
      step();
    end
    check("drain_level", 32'(level), 0);
    check("drain_req", 32'(req), 0);

    // pointer wrap
    for (int i = 5; i <= 8; i++) push_cmd(32'(i));
    check("wrap_level", 32'(level), 4);
    for (int i = 5; i <= 8; i++) begin
      grant_pulse(32'(i));
      step();
    end
    check("wrap_level_0", 32'(level), 0);

    // simultaneous push and pop at level 1
    push_cmd(32'h10);
    exp_q.push_back(32'h10);
    cmd_valid = 1'b1;
    cmd_data  = 32'h20;
    grant     = 1'b1;
    step();
    cmd_valid = 1'b0;
    grant     = 1'b0;
    check("simul_level", 32'(level), 1);
    check("simul_req", 32'(req), 1);
    step();
    grant_pulse(32'h20);
    check("simul_level_0", 32'(level), 0);
    step();

    // spurious grant
    grant = 1'b1;
    step();
    grant = 1'b0;
    check("spur_bus_valid", 32'(bus_valid), 0);
    check("spur_err", 32'(err_spurious), 1);
    check("spur_level", 32'(level), 0);
    repeat (3) step();
    check("spur_err_sticky", 32'(err_spurious), 1);
    push_cmd(32'h33);
    grant_pulse(32'h33);
    check("spur_recover_level", 32'(level), 0);
    step();

    // starvation watchdog: grant withheld 8 cycles
    do_reset();
    check("reset_clears_spur", 32'(err_spurious), 0);
    push_cmd(32'h44);
    repeat (7) step();
    check("to_before_limit", 32'(err_timeout), 0);
    step();
    check("to_at_limit", 32'(err_timeout), 32'(TO_EXP));
    grant_pulse(32'h44);
    step();
    check("to_sticky", 32'(err_timeout), 32'(TO_EXP));

    // grant just in time
    do_reset();
    check("to_reset_clear", 32'(err_timeout), 0);
    push_cmd(32'h45);
    repeat (6) step();
    grant_pulse(32'h45);
    check("to_grant7", 32'(err_timeout), 0);
    repeat (10) step();
    check("to_grant7_later", 32'(err_timeout), 0);

    // async reset mid-drain
    push_cmd(32'h61);
    push_cmd(32'h62);
    grant_pulse(32'h61);
    step();
    check("mid_req_before", 32'(req), 1);
    check("mid_level_before", 32'(level), 1);
    rst_n = 1'b0;
    #1;
    check("mid_req_async", 32'(req), 0);
    check("mid_level_async", 32'(level), 0);
    check("mid_cmd_ready", 32'(cmd_ready), 1);
    #2;
    rst_n = 1'b1;
    step();
    check("mid_req_after", 32'(req), 0);
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
